// File: rtl/mem_pkg.sv
// Shared types and widths for the main-memory responder.
package mem_pkg;

    // Responder FSM encoding
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StHold = 2'd2
    } memState_t;

    localparam int unsigned BLOCK_W         = 128;
    localparam int unsigned WORD_W          = 32;
    localparam int unsigned WORDS_PER_BLOCK = 4;
    localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/main_mem_array.sv
// Word storage: one combinational 128-bit block-read port and one write port.
// MEM_BLOCK_WRITE_EN: when defined the write port stores a whole block, otherwise one word.
// Storage is not reset; each word powers up holding its own index.
module main_mem_array
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic               clk,
    input  logic               wrEn,
    input  logic [ADDR_W-3:0]  wordAddr,
    input  logic [BLOCK_W-1:0] wrData,
    output logic [BLOCK_W-1:0] rdBlock
);

    localparam int unsigned BLK_W = ADDR_W - 4;

    logic [WORD_W-1:0] words [MEM_WORDS];
    logic [BLK_W-1:0]  blkIdx;

    assign blkIdx = wordAddr[ADDR_W-3:2];

`ifdef MEM_BLOCK_WRITE_EN
    // Word offset is irrelevant when a whole block is written
    logic unusedOffset;
    assign unusedOffset = ^wordAddr[1:0];
`else
    logic unusedHiData;
    assign unusedHiData = ^wrData[BLOCK_W-1:WORD_W];
`endif

    for (genvar i = 0; i < MEM_WORDS; i++) begin : gWord
        logic [WORD_W-1:0] wordQ = WORD_W'(i);

`ifdef MEM_BLOCK_WRITE_EN
        // Store this word's slice when its block is written (word 0 in the top slice)
        always_ff @(posedge clk) begin
            if (wrEn && blkIdx == BLK_W'(i / WORDS_PER_BLOCK)) begin
                wordQ <= wrData[BLOCK_W-1-WORD_W*(i % WORDS_PER_BLOCK) -: WORD_W];
            end
        end
`else
        // Store the low data word when this word is addressed
        always_ff @(posedge clk) begin
            if (wrEn && wordAddr == (ADDR_W-2)'(i)) begin
                wordQ <= wrData[WORD_W-1:0];
            end
        end
`endif

        assign words[i] = wordQ;
    end

    // Assemble the addressed block, lowest word in the most significant slice
    always_comb begin
        rdBlock = '0;
        for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
            rdBlock[BLOCK_W-1-WORD_W*k -: WORD_W] = words[{blkIdx, 2'(k)}];
        end
    end

endmodule

// File: rtl/main_memory_resp.sv
// Main-memory responder: captures a request on isLock low, waits LATENCY cycles, performs the
// access, pulses memReady once, then waits for isLock to rise before accepting another request.
// MEM_BLOCK_WRITE_EN selects block writes in main_mem_array.
module main_memory_resp
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned MEM_WORDS = 256,
    parameter int unsigned LATENCY   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               isLock,
    input  logic               isMemRead,
    input  logic [ADDR_W-1:0]  address,
    input  logic [BLOCK_W-1:0] memWriteData,
    output logic [BLOCK_W-1:0] memReadData,
    output logic               memReady,
    output logic               memBusy
);

    memState_t          state;
    logic [CNT_W-1:0]   cnt;
    logic [ADDR_W-3:0]  capAddr;
    logic               capRead;
    logic [BLOCK_W-1:0] capData;
    logic [BLOCK_W-1:0] rdBlock;
    logic               wrEn;

    // Byte offset never selects anything: accesses are word or block aligned
    logic unusedByteOffset;
    assign unusedByteOffset = ^address[1:0];

    // The write lands on the same edge the FSM leaves BUSY
    assign wrEn    = (state == StBusy) && (cnt == '0) && !capRead;
    assign memBusy = (state != StIdle);

    main_mem_array #(
        .ADDR_W    (ADDR_W),
        .MEM_WORDS (MEM_WORDS)
    ) uArray (
        .clk      (clk),
        .wrEn     (wrEn),
        .wordAddr (capAddr),
        .wrData   (capData),
        .rdBlock  (rdBlock)
    );

    // Request FSM, latency counter, capture registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            cnt         <= '0;
            capAddr     <= '0;
            capRead     <= 1'b0;
            capData     <= '0;
            memReadData <= '0;
            memReady    <= 1'b0;
        end else begin
            memReady <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (!isLock) begin
                        capAddr <= address[ADDR_W-1:2];
                        capRead <= isMemRead;
                        capData <= memWriteData;
                        cnt     <= CNT_W'(LATENCY - 1);
                        state   <= StBusy;
                    end
                end
                StBusy: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (capRead) begin
                            memReadData <= rdBlock;
                        end
                        memReady <= 1'b1;
                        state    <= StHold;
                    end
                end
                StHold: begin
                    // A strobe still held low must not start a second access
                    if (isLock) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
